// File: rtl/baud_pulse_gen.sv
// Baud/oversampling pulse generator: prescaler, bit-phase counter, mid/end-of-bit pulses.
// Optional fractional divisor (div_frac port + 4-bit accumulator) enabled by defining BAUD_FRAC_EN.
module baud_pulse_gen #(
  parameter int DIV_W   = 16,
  parameter int OVS     = 16,
  parameter int DIV_RST = 27
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    restart,
  input  logic [DIV_W-1:0]        div,
`ifdef BAUD_FRAC_EN
  input  logic [3:0]              div_frac,
`endif
  output logic                    sample_tick,
  output logic                    half_bit,
  output logic                    end_bit,
  output logic [$clog2(OVS)-1:0]  bit_phase
);

  localparam int PH_W = $clog2(OVS);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] presc;
  logic [DIV_W-1:0] d_eff;
  logic [DIV_W-1:0] last;
  logic [PH_W-1:0]  phase_nxt;
  logic             stretch;
  logic             wrap;

  // A zero divisor behaves as one; a pending fractional carry adds one clock to this period.
  assign d_eff     = (div_q == '0) ? DIV_W'(1) : div_q;
  assign last      = d_eff - DIV_W'(1) + DIV_W'(stretch);
  assign wrap      = enable && !restart && (presc == last);
  assign phase_nxt = (bit_phase == PH_W'(OVS - 1)) ? '0 : bit_phase + PH_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q       <= DIV_W'(DIV_RST);
      presc       <= '0;
      bit_phase   <= '0;
      sample_tick <= 1'b0;
      half_bit    <= 1'b0;
      end_bit     <= 1'b0;
    end else if (restart) begin
      div_q       <= div;
      presc       <= '0;
      bit_phase   <= '0;
      sample_tick <= 1'b0;
      half_bit    <= 1'b0;
      end_bit     <= 1'b0;
    end else if (wrap) begin
      div_q       <= div;
      presc       <= '0;
      bit_phase   <= phase_nxt;
      sample_tick <= 1'b1;
      half_bit    <= (phase_nxt == PH_W'(OVS / 2));
      end_bit     <= (phase_nxt == '0);
    end else begin
      if (enable) begin
        presc <= presc + DIV_W'(1);
      end
      sample_tick <= 1'b0;
      half_bit    <= 1'b0;
      end_bit     <= 1'b0;
    end
  end

`ifdef BAUD_FRAC_EN
  logic [3:0] frac_q;
  logic [3:0] acc;
  logic [4:0] acc_sum;

  assign acc_sum = {1'b0, acc} + {1'b0, frac_q};

  // Carry out of the accumulator stretches the following period by one clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frac_q  <= '0;
      acc     <= '0;
      stretch <= 1'b0;
    end else if (restart) begin
      frac_q  <= div_frac;
      acc     <= '0;
      stretch <= 1'b0;
    end else if (wrap) begin
      frac_q  <= div_frac;
      acc     <= acc_sum[3:0];
      stretch <= acc_sum[4];
    end
  end
`else
  assign stretch = 1'b0;
`endif

endmodule
